banked_ram_clr: RTL and testbench

//  Parametrised banked RAM: BANKS banks of 2**BANK_AW words, each WIDTH bits.

---
 rtl/banked_ram_clr.sv | 138 +++++++++++++
 tb/tb_banked_ram_clr.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/banked_ram_clr.sv
// banked_ram_clr
//   Banked word store: BANKS = 2**BANK_SW banks of 2**BANK_AW words, WIDTH bits
//   each. The top address bits select the bank and the low bits index within it.
//   The read port is registered and write-first: a word written in the current
//   cycle shows up on o at the next edge in place of the old contents.
//   A clear sequencer zeroes every word after reset or when clr is requested,
//   sweeping one index per cycle across all banks in parallel.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   in     in   WIDTH  write data
//   add    in   AW     word address {bank, index}
//   load   in   1      write enable
//   clr    in   1      clear request, honoured only in IDLE
//   o      out  WIDTH  registered read data
//   busy   out  1      clear sequencer running
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing index cnt in every bank; load/clr ignored, o held at 0
// ST_IDLE  | normal read/write; clr starts a new clear sweep
module banked_ram_clr #(
    parameter int WIDTH   = 16,
    parameter int BANK_AW = 6,
    parameter int BANK_SW = 3,
    localparam int AW     = BANK_AW + BANK_SW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    add,
    input  logic             load,
    input  logic             clr,
    output logic [WIDTH-1:0] o,
    output logic             busy
);

    localparam int BANKS = 2 ** BANK_SW;
    localparam int DEPTH = 2 ** BANK_AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BANK_AW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     o_q, o_d;
    logic                 busy_q, busy_d;

    logic [BANK_SW-1:0]   bank_sel;
    logic [BANK_AW-1:0]   idx;
    logic [BANKS-1:0]     wr_sel;
    logic                 clearing;
    logic [WIDTH-1:0]     rd_bank [BANKS];

    assign bank_sel = add[AW-1:BANK_AW];
    assign idx      = add[BANK_AW-1:0];
    assign clearing = (state_q == ST_CLEAR);

    // One-hot write decode; a clr in the same cycle drops the write.
    always_comb begin
        wr_sel = '0;
        if (state_q == ST_IDLE && load && !clr) begin
            wr_sel[bank_sel] = 1'b1;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [DEPTH];

        // Storage is deliberately not reset; the clear sweep initialises it.
        always_ff @(posedge clk) begin
            if (clearing) begin
                mem[cnt_q] <= '0;
            end else if (wr_sel[b]) begin
                mem[idx] <= in;
            end
        end

        assign rd_bank[b] = mem[idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                o_d = '0;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + BANK_AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    // Write is dropped, so o shows the stored word, not in.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    o_d     = rd_bank[bank_sel];
                end else begin
                    o_d = load ? in : rd_bank[bank_sel];
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
                o_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            o_q     <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
        end
    end

    assign o    = o_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_banked_ram_clr.sv
// tb_banked_ram_clr
//   Self-checking bench for banked_ram_clr at default parameters (512 x 16).
//   A flat 512-word array plus a "cycles of clear left" counter models the
//   block; every clock edge is compared against it, and a vector table plus
//   directed sequences cover the named corner cases.
module tb_banked_ram_clr;

    localparam int CLEAR_CYCLES = 64;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [8:0]  add;
    logic        load;
    logic        clr;
    logic [15:0] o;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_mem [512];
    logic [15:0] m_o;
    int          m_busy_left;

    banked_ram_clr dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (din),
        .add  (add),
        .load (load),
        .clr  (clr),
        .o    (o),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        clr;
        logic [8:0]  add;
        logic [15:0] din;
        logic [15:0] exp_o;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy_left = CLEAR_CYCLES;
        m_o         = '0;
    endtask

    // One clock edge: advance the model from the inputs present at the edge,
    // then compare outputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (m_busy_left > 0) begin
            m_o = '0;
            m_busy_left--;
            if (m_busy_left == 0) begin
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else if (clr) begin
            m_o         = m_mem[add];
            m_busy_left = CLEAR_CYCLES;
        end else begin
            m_o = load ? din : m_mem[add];
            if (load) m_mem[add] = din;
        end
        #1;
        check("o", 32'(o), 32'(m_o));
        check("busy", 32'(busy), 32'(m_busy_left > 0));
    endtask

    // Ticks until busy drops (bounded) and returns how many edges it took.
    task automatic count_busy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 200);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_o", 32'(o), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        din   = '0;
        add   = '0;
        load  = 1'b0;
        clr   = 1'b0;
        model_reset();

        // Power-up, with a write attempted throughout the clear.
        do_reset();
        load = 1'b1; din = 16'hFFFF; add = 9'd5;
        count_busy(n);
        check("powerup_clear_len", 32'(n), 32'(CLEAR_CYCLES));
        load = 1'b0;

        // Vector table: post-clear reads, write/read, bank isolation, bypass.
        vecs.push_back('{1'b0, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h03F, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h040, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h1FF, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h005, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 9'h041, 16'hBEEF, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h041, 16'h7777, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h001, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h081, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 9'h1FF, 16'h1234, 16'h1234, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h0FF, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h1FF, 16'h0000, 16'h1234, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 9'h041, 16'h5555, 16'h5555, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 9'h041, 16'h0000, 16'h5555, 1'b0});
        foreach (vecs[i]) begin
            load = vecs[i].load; clr = vecs[i].clr;
            add  = vecs[i].add;  din = vecs[i].din;
            tick();
            check($sformatf("vec%0d_o", i), 32'(o), 32'(vecs[i].exp_o));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // Fill every word with its own address, then clear with a colliding write.
        for (int a = 0; a < 512; a++) begin
            load = 1'b1; add = 9'(a); din = 16'(a);
            tick();
        end
        load = 1'b0;
        add  = 9'h0C3;
        tick();
        check("fill_readback", 32'(o), 32'h00C3);
        clr = 1'b1; load = 1'b1; din = 16'hABCD; add = 9'd7;
        tick();
        check("clr_read_o", 32'(o), 32'h0007);
        clr = 1'b0; load = 1'b0;
        count_busy(n);
        check("clr_clear_len", 32'(n), 32'(CLEAR_CYCLES));
        for (int a = 0; a < 512; a++) begin
            add = 9'(a);
            tick();
            if (o !== 16'h0) check($sformatf("cleared_%0d", a), 32'(o), 32'h0);
        end
        add = 9'd7;
        tick();
        check("clr_write_dropped", 32'(o), 32'h0);

        // Randomised traffic with occasional clear requests.
        for (int c = 0; c < 3000; c++) begin
            load = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 149) == 0);
            add  = 9'($urandom);
            din  = 16'($urandom);
            tick();
        end
        load = 1'b0; clr = 1'b0;
        n = 0;
        while (m_busy_left > 0 && n < 100) begin tick(); n++; end

        // Reset mid-operation with non-zero o, then reset at clear cycle 30.
        load = 1'b1; add = 9'd3; din = 16'h5A5A;
        tick();
        check("pre_reset_o", 32'(o), 32'h5A5A);
        load = 1'b0;
        do_reset();
        count_busy(n);
        check("reset_clear_len", 32'(n), 32'(CLEAR_CYCLES));
        add = 9'd3;
        tick();
        check("reset_clear_addr3", 32'(o), 32'h0);
        load = 1'b1; add = 9'd9; din = 16'hC0DE;
        tick();
        load = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (30) tick();
        do_reset();
        count_busy(n);
        check("midclear_clear_len", 32'(n), 32'(CLEAR_CYCLES));
        add = 9'd9;
        tick();
        check("midclear_addr9", 32'(o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
